// File: rtl/button_event_gen.sv
// Turns a debounced button level into registered one-cycle UI events
// (press, short/long release, long press, auto-repeat) plus a held level.
module button_event_gen #(
  parameter int LONG_CNT   = 50_000_000,
  parameter int REPEAT_CNT = 10_000_000,
  parameter int CNT_W      = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic press,
  output logic short_release,
  output logic long_press,
  output logic repeat_pulse,
  output logic long_release,
  output logic held
);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    LONG     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             press_next, short_release_next, long_press_next;
  logic             repeat_pulse_next, long_release_next, held_next;

  // Counter counts edges spent in the current state; the threshold edge
  // fires the pulse so it appears exactly LONG_CNT / REPEAT_CNT cycles later.
  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    press_next         = 1'b0;
    short_release_next = 1'b0;
    long_press_next    = 1'b0;
    repeat_pulse_next  = 1'b0;
    long_release_next  = 1'b0;
    case (state_reg)
      WAIT_LOW: begin
        if (!btn_level) state_next = IDLE;
      end
      IDLE: begin
        if (btn_level) begin
          state_next = PRESSED;
          press_next = 1'b1;
          cnt_next   = '0;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          state_next         = IDLE;
          short_release_next = 1'b1;
        end else if (cnt_reg == LONG_LAST) begin
          state_next      = LONG;
          long_press_next = 1'b1;
          cnt_next        = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      LONG: begin
        if (!btn_level) begin
          state_next        = IDLE;
          long_release_next = 1'b1;
        end else if (cnt_reg == REPEAT_LAST) begin
          repeat_pulse_next = 1'b1;
          cnt_next          = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = WAIT_LOW;
    endcase
    held_next = (state_next == PRESSED) || (state_next == LONG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= WAIT_LOW;
      cnt_reg       <= '0;
      press         <= 1'b0;
      short_release <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      long_release  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      press         <= press_next;
      short_release <= short_release_next;
      long_press    <= long_press_next;
      repeat_pulse  <= repeat_pulse_next;
      long_release  <= long_release_next;
      held          <= held_next;
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen with LONG_CNT=8, REPEAT_CNT=3:
// per-cycle expected outputs are queued as stimulus is driven and checked after each edge.
module tb_button_event_gen;

  localparam int N = 48;
  // vector bit positions: {held, long_release, repeat_pulse, long_press, short_release, press}
  localparam int B_PRESS = 0, B_SR = 1, B_LP = 2, B_RP = 3, B_LR = 4, B_HELD = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_level = 1'b0;
  logic press, short_release, long_press, repeat_pulse, long_release, held;

  button_event_gen #(.LONG_CNT(8), .REPEAT_CNT(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .btn_level(btn_level),
    .press(press), .short_release(short_release), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .long_release(long_release), .held(held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] v;
    string      tag;
  } exp_t;

  exp_t       sb_q[$];
  logic       lvl_tab[0:63];
  logic       rst_tab[0:63];
  logic [5:0] exp_tab[0:63];
  int         n_vec = 0;
  int         n_err = 0;
  bit         done = 1'b0;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%b want=%b (held,lr,rp,lp,sr,press)", tag, got, want);
    end
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < 64; i++) begin
      lvl_tab[i] = 1'b0;
      rst_tab[i] = 1'b0;
      exp_tab[i] = '0;
    end
  endtask

  task automatic lvl_range(input int a, input int b);
    for (int i = a; i <= b; i++) lvl_tab[i] = 1'b1;
  endtask

  task automatic held_range(input int a, input int b);
    for (int i = a; i <= b; i++) exp_tab[i][B_HELD] = 1'b1;
  endtask

  task automatic ev(input int cyc, input int bitpos);
    exp_tab[cyc][bitpos] = 1'b1;
  endtask

  // Edge e samples lvl_tab[e]; its result is expected in cycle e+1.
  task automatic run_scn(input string name);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      btn_level = lvl_tab[i];
      rst       = rst_tab[i];
      e.v   = exp_tab[i+1];
      e.tag = $sformatf("%s_c%0d", name, i + 1);
      sb_q.push_back(e);
    end
    $display("scenario %s driven, %0d cycles queued", name, N);
  endtask

  // Monitor: one comparison per queued cycle, sampled after the edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.tag, {held, long_release, repeat_pulse, long_press, short_release, press}, e.v);
      $display("cycle %s out=%b exp=%b", e.tag,
               {held, long_release, repeat_pulse, long_press, short_release, press}, e.v);
    end
  end

  initial begin
    // Reset with the button held through it: no events at all.
    clear_tabs();
    rst_tab[0] = 1'b1; rst_tab[1] = 1'b1;
    lvl_range(0, 5);
    run_scn("reset_held");

    // 1. short tap
    clear_tabs();
    lvl_range(10, 13);
    ev(11, B_PRESS); ev(15, B_SR); held_range(11, 14);
    run_scn("short_tap");

    // 2. long hold with two repeats
    clear_tabs();
    lvl_range(10, 26);
    ev(11, B_PRESS); ev(19, B_LP); ev(22, B_RP); ev(25, B_RP); ev(28, B_LR);
    held_range(11, 27);
    run_scn("long_hold");

    // 3. release on the long-press threshold edge
    clear_tabs();
    lvl_range(10, 17);
    ev(11, B_PRESS); ev(19, B_SR); held_range(11, 18);
    run_scn("thresh_race");

    // 4. release on the repeat edge
    clear_tabs();
    lvl_range(10, 20);
    ev(11, B_PRESS); ev(19, B_LP); ev(22, B_LR); held_range(11, 21);
    run_scn("repeat_race");

    // 5. reset mid-hold, then a fresh tap
    clear_tabs();
    lvl_range(10, 29);
    rst_tab[15] = 1'b1;
    ev(11, B_PRESS); held_range(11, 15);
    lvl_range(35, 37);
    ev(36, B_PRESS); ev(39, B_SR); held_range(36, 38);
    run_scn("reset_mid");

    // 6. back-to-back taps
    clear_tabs();
    lvl_tab[10] = 1'b1; lvl_tab[12] = 1'b1;
    ev(11, B_PRESS); ev(12, B_SR); ev(13, B_PRESS); ev(14, B_SR);
    held_range(11, 11); held_range(13, 13);
    run_scn("back2back");

    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_drain got=%0d want=0 entries left", sb_q.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
    end
  end

endmodule
